// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit
// Function : RV32I fetch stage with one outstanding request, 2-entry buffer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic        req_valid, req_valid_nxt;
    logic        discard, discard_nxt;
    logic        fault, fault_nxt;
    logic [1:0]  count, count_nxt;
    logic [31:0] inst0, inst0_nxt, inst1, inst1_nxt;
    logic [31:0] pc0, pc0_nxt, pc1, pc1_nxt;
    logic        accept, rsp_take, push, pop, flush;

    always_comb begin
        accept        = req_valid & imem_req_ready;
        rsp_take      = (state == S_WAIT) & imem_rsp_valid;
        state_nxt     = state;
        pc_nxt        = pc;
        discard_nxt   = discard;
        fault_nxt     = fault;
        push          = 1'b0;
        flush         = 1'b0;
        count_nxt     = count;
        inst0_nxt     = inst0;
        inst1_nxt     = inst1;
        pc0_nxt       = pc0;
        pc1_nxt       = pc1;
        req_valid_nxt = 1'b0;
        req_addr_nxt  = req_addr;

        unique case (state)
            S_REQ: begin
                if (accept) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // The only outstanding response ends the discard window either way.
                if (rsp_take) begin
                    state_nxt   = S_REQ;
                    discard_nxt = 1'b0;
                    if (!discard && !redirect_valid) begin
                        push   = 1'b1;
                        pc_nxt = pc + 32'd4;
                    end
                end
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: state_nxt = S_FAULT;
        endcase

        if (redirect_valid && state != S_FAULT) begin
            flush = 1'b1;
            if (redirect_target[1:0] != 2'b00) begin
                fault_nxt = 1'b1;
                state_nxt = S_FAULT;
            end else begin
                pc_nxt = redirect_target;
                if (req_valid || (state == S_WAIT && !rsp_take))
                    discard_nxt = 1'b1;
            end
        end

        pop = (count != 2'd0) & inst_ready & ~flush;

        // Shift-style buffer: entry 0 is always the head seen by decode.
        if (flush) begin
            count_nxt = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        inst0_nxt = imem_rsp_data;
                        pc0_nxt   = req_addr;
                    end else begin
                        inst1_nxt = imem_rsp_data;
                        pc1_nxt   = req_addr;
                    end
                    count_nxt = count + 2'd1;
                end
                2'b01: begin
                    inst0_nxt = inst1;
                    pc0_nxt   = pc1;
                    count_nxt = count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        inst0_nxt = imem_rsp_data;
                        pc0_nxt   = req_addr;
                    end else begin
                        inst0_nxt = inst1;
                        pc0_nxt   = pc1;
                        inst1_nxt = imem_rsp_data;
                        pc1_nxt   = req_addr;
                    end
                end
                default: ;
            endcase
        end

        // A raised request is held with a stable address until accepted.
        if (req_valid && !imem_req_ready) begin
            req_valid_nxt = 1'b1;
        end else if (state_nxt == S_REQ && !discard_nxt &&
                     ({30'd0, count_nxt} < FIFO_DEPTH)) begin
            req_valid_nxt = 1'b1;
            req_addr_nxt  = pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            req_valid <= 1'b0;
            discard   <= 1'b0;
            fault     <= 1'b0;
            count     <= 2'd0;
            inst0     <= 32'd0;
            inst1     <= 32'd0;
            pc0       <= 32'd0;
            pc1       <= 32'd0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            req_addr  <= req_addr_nxt;
            req_valid <= req_valid_nxt;
            discard   <= discard_nxt;
            fault     <= fault_nxt;
            count     <= count_nxt;
            inst0     <= inst0_nxt;
            inst1     <= inst1_nxt;
            pc0       <= pc0_nxt;
            pc1       <= pc1_nxt;
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = req_addr;
    assign inst_valid     = (count != 2'd0);
    assign inst           = inst0;
    assign inst_pc        = pc0;
    assign opcode         = inst0[6:0];
    assign funct3         = inst0[14:12];
    assign funct7         = inst0[30];
    assign fetch_fault    = fault;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_unit
// Function : Self-checking bench for fetch_unit with a latency-variable memory.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic        fetch_fault;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .fetch_fault(fetch_fault)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
    } vec_t;

    vec_t        tbl[5];
    logic [31:0] sb[$];
    logic [31:0] req_log[$];
    int          checks = 0;
    int          errors = 0;
    int          lat    = 1;
    logic        inject = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        for (int i = 0; i < 5; i++)
            if (tbl[i].addr == a) return tbl[i].word;
        return {a[23:0], 8'h00} ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory model: one response, lat cycles after acceptance.
    initial begin : g_memory
        logic        acc, pend;
        logic [31:0] acc_addr, paddr;
        int          cnt;
        pend = 1'b0; cnt = 0; paddr = 32'd0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            acc      = imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'd0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (acc) begin
                    pend  = 1'b1;
                    cnt   = lat - 1;
                    paddr = acc_addr;
                end
                if (inject) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = 32'hDEAD_BEEF;
                end else if (pend) begin
                    if (cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_word(paddr);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // One clock: sample handshakes at negedge, return just after the next edge.
    task automatic step();
        logic [31:0] e, w;
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
        if (inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_delivery_pc", inst_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                w = mem_word(e);
                chk("deliver_pc", inst_pc, e);
                chk("deliver_inst", inst, w);
                chk("deliver_fields", {20'd0, opcode, funct3, funct7},
                    {20'd0, w[6:0], w[14:12], w[30]});
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic run_until_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        sb.delete();
        req_log.delete();
        rst = 1'b1;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        imem_req_ready = 1'b1;
        step();
        step();
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
        step();
        redirect_valid  = 1'b0;
    endtask

    initial begin : g_main
        int          n, idx, unstable;
        logic [31:0] hpc, hinst;
        tbl[0] = '{32'h0000_0300, 32'h0000_0013, 7'h13, 3'd0, 1'b0};
        tbl[1] = '{32'h0000_0400, 32'h4000_0033, 7'h33, 3'd0, 1'b1};
        tbl[2] = '{32'h0000_0500, 32'h0020_A023, 7'h23, 3'd2, 1'b0};
        tbl[3] = '{32'h0000_0600, 32'h4050_D093, 7'h13, 3'd5, 1'b1};
        tbl[4] = '{32'h0000_0700, 32'hFFFF_FFFF, 7'h7F, 3'd7, 1'b1};
        rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'd0;
        inst_ready = 1'b0; imem_req_ready = 1'b1;

        // Reset state and the first three sequential fetches.
        lat = 1;
        do_reset();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_fault", fetch_fault, 0);
        inst_ready = 1'b1;
        sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
        rst = 1'b0;
        n = 0;
        while (!inst_valid && n < 20) begin step(); n++; end
        chk("first_valid_latency", n, 3);
        run_until_empty(40);
        inst_ready = 1'b0;
        chk("req_log_size", (req_log.size() >= 3), 1);
        if (req_log.size() >= 3) begin
            chk("req_addr0", req_log[0], 32'h0);
            chk("req_addr1", req_log[1], 32'h4);
            chk("req_addr2", req_log[2], 32'h8);
        end

        // Decode backpressure: buffer fills, head is held, then drains in order.
        unstable = 0; hpc = 32'd0; hinst = 32'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 3) begin hpc = inst_pc; hinst = inst; end
            else if (i > 3 && (inst_pc !== hpc || inst !== hinst)) unstable++;
        end
        chk("hold_stable", unstable, 0);
        chk("full_no_req", imem_req_valid, 0);
        chk("full_valid", inst_valid, 1);
        chk("full_head_pc", inst_pc, 32'hC);
        sb.push_back(32'hC); sb.push_back(32'h10);
        sb.push_back(32'h14); sb.push_back(32'h18);
        inst_ready = 1'b1;
        run_until_empty(40);
        inst_ready = 1'b0;

        // Redirect while the response for 0x8 is outstanding.
        lat = 3;
        do_reset();
        rst = 1'b0;
        inst_ready = 1'b1;
        sb.push_back(32'h0); sb.push_back(32'h4);
        sb.push_back(32'h100); sb.push_back(32'h104);
        n = 0;
        while (req_log.size() < 3 && n < 60) begin step(); n++; end
        chk("wait_req8", (req_log.size() >= 3) ? req_log[2] : 32'hFFFF_FFFF, 32'h8);
        redirect(32'h100);
        run_until_empty(80);
        inst_ready = 1'b0;

        // Redirect in the same cycle as a response.
        lat = 2;
        do_reset();
        rst = 1'b0;
        inst_ready = 1'b1;
        sb.push_back(32'h0); sb.push_back(32'h200); sb.push_back(32'h204);
        n = 0;
        while (!(imem_rsp_valid && req_log.size() == 2) && n < 60) begin step(); n++; end
        chk("wait_rsp4", imem_rsp_valid, 1);
        redirect(32'h200);
        run_until_empty(60);
        inst_ready = 1'b0;

        // Request held unaccepted across a redirect.
        lat = 1;
        do_reset();
        imem_req_ready = 1'b0;
        rst = 1'b0;
        inst_ready = 1'b1;
        step();
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            if (!(imem_req_valid === 1'b1 && imem_req_addr === 32'h0)) unstable++;
            redirect_valid  = (i == 1);
            redirect_target = 32'h800;
            step();
        end
        redirect_valid = 1'b0;
        chk("pending_held", unstable, 0);
        chk("pending_addr", imem_req_addr, 32'h0);
        imem_req_ready = 1'b1;
        sb.push_back(32'h800); sb.push_back(32'h804);
        run_until_empty(40);
        inst_ready = 1'b0;
        chk("pend_log0", (req_log.size() >= 2) ? req_log[0] : 32'hFFFF_FFFF, 32'h0);
        chk("pend_log1", (req_log.size() >= 2) ? req_log[1] : 32'hFFFF_FFFF, 32'h800);

        // Field slicing on known instruction words.
        for (int v = 0; v < 5; v++) begin
            redirect(tbl[v].addr);
            n = 0;
            while (!inst_valid && n < 20) begin step(); n++; end
            chk("tbl_pc", inst_pc, tbl[v].addr);
            chk("tbl_inst", inst, tbl[v].word);
            chk("tbl_opcode", {25'd0, opcode}, {25'd0, tbl[v].opc});
            chk("tbl_funct3", {29'd0, funct3}, {29'd0, tbl[v].f3});
            chk("tbl_funct7", {31'd0, funct7}, {31'd0, tbl[v].f7});
        end

        // PC wrap at the top of the address space.
        req_log.delete();
        redirect(32'hFFFF_FFFC);
        inst_ready = 1'b1;
        sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0);
        run_until_empty(40);
        inst_ready = 1'b0;
        idx = -1;
        foreach (req_log[i]) if (idx < 0 && req_log[i] == 32'hFFFF_FFFC) idx = i;
        chk("wrap_next_addr",
            (idx >= 0 && idx + 1 < req_log.size()) ? req_log[idx+1] : 32'hFFFF_FFFF, 32'h0);

        // Misaligned redirect: sticky fault, no more requests until reset.
        for (int i = 0; i < 10; i++) step();
        redirect(32'h102);
        chk("fault_set", fetch_fault, 1);
        chk("fault_flush", inst_valid, 0);
        req_log.delete();
        inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("fault_no_reqs", req_log.size(), 0);
        chk("fault_req_valid", imem_req_valid, 0);
        chk("fault_sticky", fetch_fault, 1);

        // Stray response right after reset is ignored.
        do_reset();
        chk("fault_cleared", fetch_fault, 0);
        inject = 1'b1;
        rst = 1'b0;
        inst_ready = 1'b1;
        sb.push_back(32'h0); sb.push_back(32'h4);
        step();
        inject = 1'b0;
        run_until_empty(40);
        inst_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
